// File: rtl/hilo_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_ctrl
//   EX-stage controller for the multiply/divide units and owner of the
//   architectural HI/LO registers. Decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO,
//   pulses the unit start, stalls EX until the ALU reports completion and
//   commits the captured result into HI/LO once the instruction can retire.
//   Flushes and downstream holds never re-issue an operation or corrupt HI/LO.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   ex_valid, ex_op     EX instruction valid and decoded muldiv/move opcode
//   rs_val, rt_val      rs (MTHI/MTLO source) and rt (divisor zero check)
//   flush, pipe_hold    cancel EX instruction / downstream stall
//   alu_mult_start/sign, alu_diver_start/div_sign   unit start and signedness
//   alu_opreat_over     ALU units idle/finished
//   alu_mult_result     {hi,lo} product
//   alu_diver_result    {remainder,quotient}
//   ex_stall            hold EX stage
//   hi, lo              architectural HI/LO
//   err                 one-cycle pulse on completion timeout
// ---------------------------------------------------------------------------
module hilo_muldiv_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [2:0]  ex_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  input  logic        pipe_hold,
  output logic        alu_mult_start,
  output logic        alu_mult_sign,
  output logic        alu_diver_start,
  output logic        alu_div_sign,
  input  logic        alu_opreat_over,
  input  logic [63:0] alu_mult_result,
  input  logic [63:0] alu_diver_result,
  output logic        ex_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT0 = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam int unsigned CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  // Counter value during the last permitted waiting cycle.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [31:0]   phi;
  logic [31:0]   plo;
  logic          pend_div;
  logic          mult_sign_q;
  logic          div_sign_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic          err_q;

  logic op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo;
  logic is_muldiv, is_divop, issue, issue_idle, move_ok, timeout_hit;
  logic cnt_clr, cnt_inc, capture, commit, timeout;

  // Opcode decode and issue qualification.
  always_comb begin
    op_mult   = (ex_op == 3'b001);
    op_multu  = (ex_op == 3'b010);
    op_div    = (ex_op == 3'b011);
    op_divu   = (ex_op == 3'b100);
    op_mthi   = (ex_op == 3'b101);
    op_mtlo   = (ex_op == 3'b110);
    is_muldiv = op_mult | op_multu | op_div | op_divu;
    is_divop  = op_div | op_divu;
    // A divide by zero never reaches the divider; it retires with HI/LO untouched.
    issue      = ex_valid & ~flush & is_muldiv & ~(is_divop & (rt_val == 32'd0));
    issue_idle = (state == IDLE) & issue;
    move_ok    = ((state == IDLE) | (state == DRAIN)) & ex_valid & ~flush & ~pipe_hold;
    timeout_hit = (cnt == CNT_LAST);
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_n = state;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    capture = 1'b0;
    commit  = 1'b0;
    timeout = 1'b0;
    case (state)
      IDLE: begin
        if (issue) begin
          state_n = WAIT0;
          cnt_clr = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      WAIT0: begin
        // opreat_over is still the stale idle level here; the ALU drops it next cycle.
        if (flush) begin
          state_n = DRAIN;
          cnt_clr = 1'b1;
        end else if (timeout_hit) begin
          state_n = IDLE;
          timeout = 1'b1;
        end else begin
          state_n = WAIT;
          cnt_inc = 1'b1;
        end
      end
      WAIT: begin
        if (flush && alu_opreat_over) begin
          // Units already finished: nothing left to drain, just drop the result.
          state_n = IDLE;
        end else if (flush) begin
          state_n = DRAIN;
          cnt_clr = 1'b1;
        end else if (alu_opreat_over) begin
          state_n = DONE;
          capture = 1'b1;
        end else if (timeout_hit) begin
          state_n = IDLE;
          timeout = 1'b1;
        end else begin
          state_n = WAIT;
          cnt_inc = 1'b1;
        end
      end
      DONE: begin
        if (flush) begin
          state_n = IDLE;
        end else if (!pipe_hold) begin
          state_n = IDLE;
          commit  = 1'b1;
        end else begin
          state_n = DONE;
        end
      end
      DRAIN: begin
        if (alu_opreat_over) begin
          state_n = IDLE;
        end else if (timeout_hit) begin
          state_n = IDLE;
          timeout = 1'b1;
        end else begin
          state_n = DRAIN;
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Timeout counter for the waiting states.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (cnt_inc) begin
      cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

  // Latch operation kind and signedness at issue so they stay stable until completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_div    <= 1'b0;
      mult_sign_q <= 1'b0;
      div_sign_q  <= 1'b0;
    end else if (issue_idle) begin
      pend_div    <= is_divop;
      mult_sign_q <= op_mult;
      div_sign_q  <= op_div;
    end else begin
      pend_div    <= pend_div;
      mult_sign_q <= mult_sign_q;
      div_sign_q  <= div_sign_q;
    end
  end

  // Pending result capture; divide result is {remainder,quotient} -> {HI,LO}.
  always_ff @(posedge clk) begin
    if (rst) begin
      phi <= 32'd0;
      plo <= 32'd0;
    end else if (capture) begin
      if (pend_div) begin
        phi <= alu_diver_result[63:32];
        plo <= alu_diver_result[31:0];
      end else begin
        phi <= alu_mult_result[63:32];
        plo <= alu_mult_result[31:0];
      end
    end else begin
      phi <= phi;
      plo <= plo;
    end
  end

  // Architectural HI: muldiv commit or MTHI (never in the same state).
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= 32'd0;
    end else if (commit) begin
      hi_q <= phi;
    end else if (move_ok && op_mthi) begin
      hi_q <= rs_val;
    end else begin
      hi_q <= hi_q;
    end
  end

  // Architectural LO: muldiv commit or MTLO.
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q <= 32'd0;
    end else if (commit) begin
      lo_q <= plo;
    end else if (move_ok && op_mtlo) begin
      lo_q <= rs_val;
    end else begin
      lo_q <= lo_q;
    end
  end

  // Registered timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= timeout;
    end
  end

  // Start pulses, signedness (live on issue, held afterwards) and stall.
  always_comb begin
    alu_mult_start  = issue_idle & ~is_divop;
    alu_diver_start = issue_idle & is_divop;
    if (issue_idle) begin
      alu_mult_sign = op_mult;
      alu_div_sign  = op_div;
    end else begin
      alu_mult_sign = mult_sign_q;
      alu_div_sign  = div_sign_q;
    end
    ex_stall = issue_idle | (state == WAIT0) | (state == WAIT) |
               ((state == DRAIN) & ex_valid & is_muldiv);
  end

  assign hi  = hi_q;
  assign lo  = lo_q;
  assign err = err_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
module tb_hilo_muldiv_ctrl;
  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        pipe_hold;
  logic        alu_mult_start;
  logic        alu_mult_sign;
  logic        alu_diver_start;
  logic        alu_div_sign;
  logic        alu_opreat_over;
  logic [63:0] alu_mult_result;
  logic [63:0] alu_diver_result;
  logic        ex_stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        err;

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int s0;

  hilo_muldiv_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op(ex_op),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .pipe_hold(pipe_hold),
    .alu_mult_start(alu_mult_start), .alu_mult_sign(alu_mult_sign),
    .alu_diver_start(alu_diver_start), .alu_div_sign(alu_div_sign),
    .alu_opreat_over(alu_opreat_over), .alu_mult_result(alu_mult_result),
    .alu_diver_result(alu_diver_result), .ex_stall(ex_stall),
    .hi(hi), .lo(lo), .err(err)
  );

  always #5 clk = ~clk;

  // Count start pulses seen at the active edge.
  always @(posedge clk) begin
    if (!rst && (alu_mult_start || alu_diver_start)) starts <= starts + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one muldiv op from IDLE; over returns 6 cycles after start; hold DONE for hold_cyc.
  task automatic run_op(input logic [2:0] op, input logic [31:0] rt,
                        input logic [63:0] mres, input logic [63:0] dres,
                        input int hold_cyc,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic [31:0] old_hi, input logic [31:0] old_lo);
    logic is_div;
    logic exp_sign;
    is_div   = (op == 3'b011) || (op == 3'b100);
    exp_sign = (op == 3'b001) || (op == 3'b011);
    ex_valid = 1'b1; ex_op = op; rt_val = rt;
    alu_mult_result = mres; alu_diver_result = dres; alu_opreat_over = 1'b1;
    #1;
    check("start", is_div ? alu_diver_start : alu_mult_start, 1'b1);
    check("other_start", is_div ? alu_mult_start : alu_diver_start, 1'b0);
    check("sign", is_div ? alu_div_sign : alu_mult_sign, exp_sign);
    check("stall_issue", ex_stall, 1'b1);
    tick();
    alu_opreat_over = 1'b0;
    #1;
    check("start_once", alu_mult_start | alu_diver_start, 1'b0);
    for (int i = 1; i < 6; i++) begin
      check("stall_wait", ex_stall, 1'b1);
      check("sign_held", is_div ? alu_div_sign : alu_mult_sign, exp_sign);
      tick();
    end
    alu_opreat_over = 1'b1;
    #1;
    check("stall_over", ex_stall, 1'b1);
    tick();
    pipe_hold = (hold_cyc > 0);
    #1;
    check("stall_done", ex_stall, 1'b0);
    for (int i = 0; i < hold_cyc; i++) begin
      check("hold_hi", hi, old_hi);
      check("hold_lo", lo, old_lo);
      check("hold_stall", ex_stall, 1'b0);
      tick();
    end
    pipe_hold = 1'b0;
    #1;
    check("pre_commit_hi", hi, old_hi);
    tick();
    ex_valid = 1'b0; ex_op = 3'b000;
    check("hi", hi, exp_hi);
    check("lo", lo, exp_lo);
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_op = 3'b000; rs_val = 32'd0; rt_val = 32'd0;
    flush = 1'b0; pipe_hold = 1'b0; alu_opreat_over = 1'b1;
    alu_mult_result = 64'd0; alu_diver_result = 64'd0;
    tick(); tick();
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_err", err, 1'b0);
    check("rst_stall", ex_stall, 1'b0);
    check("rst_start", alu_mult_start | alu_diver_start, 1'b0);
    rst = 1'b0;
    tick();

    // MULT -3 * 5 = -15
    rs_val = 32'hFFFF_FFFD;
    run_op(3'b001, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 64'h5555_5555_AAAA_AAAA, 0,
           32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'd0, 32'd0);
    check("starts_mult", starts, 1);

    // DIVU 7/2 -> q=3 r=1; DIV -7/2 -> q=-3 r=-1
    run_op(3'b100, 32'd2, 64'hDEAD_BEEF_CAFE_F00D, 64'h0000_0001_0000_0003, 0,
           32'd1, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op(3'b011, 32'd2, 64'hDEAD_BEEF_CAFE_F00D, 64'hFFFF_FFFF_FFFF_FFFD, 0,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1, 32'd3);

    // MTHI/MTLO then DIV by zero
    ex_valid = 1'b1; ex_op = 3'b101; rs_val = 32'h11;
    #1 check("mthi_stall", ex_stall, 1'b0);
    tick();
    ex_op = 3'b110; rs_val = 32'h22;
    tick();
    check("mthi_hi", hi, 32'h11);
    check("mtlo_lo", lo, 32'h22);
    s0 = starts;
    ex_op = 3'b011; rt_val = 32'd0;
    #1;
    check("dz_start", alu_diver_start | alu_mult_start, 1'b0);
    check("dz_stall", ex_stall, 1'b0);
    tick();
    ex_valid = 1'b0; ex_op = 3'b000;
    tick();
    check("dz_hi", hi, 32'h11);
    check("dz_lo", lo, 32'h22);
    check("dz_starts", starts, s0);

    // Flush two cycles after MULT start, then DRAIN behaviour
    ex_valid = 1'b1; ex_op = 3'b001; rt_val = 32'd7; alu_opreat_over = 1'b1;
    alu_mult_result = 64'h1234_5678_9ABC_DEF0;
    #1 check("fl_start", alu_mult_start, 1'b1);
    tick();
    alu_opreat_over = 1'b0;
    tick();
    flush = 1'b1;
    #1 check("fl_stall_wait", ex_stall, 1'b1);
    tick();
    flush = 1'b0; ex_op = 3'b010;
    #1;
    check("drain_stall", ex_stall, 1'b1);
    check("drain_nostart", alu_mult_start, 1'b0);
    tick();
    check("drain_hi", hi, 32'h11);
    ex_op = 3'b101; rs_val = 32'h0000_ABCD;
    #1 check("drain_mthi_stall", ex_stall, 1'b0);
    tick();
    check("drain_mthi_hi", hi, 32'h0000_ABCD);
    check("drain_lo", lo, 32'h22);
    ex_op = 3'b010; alu_opreat_over = 1'b1;
    #1;
    check("drain_over_stall", ex_stall, 1'b1);
    check("drain_over_nostart", alu_mult_start, 1'b0);
    tick();
    run_op(3'b010, 32'd9, 64'h0000_0002_0000_0004, 64'hDEAD_BEEF_DEAD_BEEF, 0,
           32'd2, 32'd4, 32'h0000_ABCD, 32'h22);
    check("fl_starts", starts, s0 + 2);

    // pipe_hold for 3 cycles at completion
    s0 = starts;
    run_op(3'b001, 32'd3, 64'h0000_0000_0000_0030, 64'hDEAD_BEEF_DEAD_BEEF, 3,
           32'd0, 32'h30, 32'd2, 32'd4);
    check("hold_starts", starts, s0 + 1);

    // Timeout: over never returns
    ex_valid = 1'b1; ex_op = 3'b001; alu_opreat_over = 1'b1;
    #1 check("to_start", alu_mult_start, 1'b1);
    tick();
    alu_opreat_over = 1'b0; ex_valid = 1'b0; ex_op = 3'b000;
    for (int i = 1; i < TO; i++) begin
      check("to_err_early", err, 1'b0);
      tick();
    end
    check("to_err_last", err, 1'b0);
    check("to_stall_last", ex_stall, 1'b1);
    tick();
    check("to_err", err, 1'b1);
    check("to_stall_idle", ex_stall, 1'b0);
    check("to_hi", hi, 32'd0);
    check("to_lo", lo, 32'h30);
    tick();
    check("to_err_pulse", err, 1'b0);

    // Reset in the middle of WAIT
    ex_valid = 1'b1; ex_op = 3'b011; rt_val = 32'd2; alu_opreat_over = 1'b1;
    #1 check("rw_start", alu_diver_start, 1'b1);
    tick();
    alu_opreat_over = 1'b0; ex_valid = 1'b0; ex_op = 3'b000;
    tick();
    check("rw_stall", ex_stall, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0; alu_opreat_over = 1'b1;
    check("rw_hi", hi, 32'd0);
    check("rw_lo", lo, 32'd0);
    check("rw_stall_clr", ex_stall, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Initiator side of the multiply/divide start/opreat_over handshake. The ALU datapath exposes that handshake through its mult and diver units.
- Sits in the EX stage and decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Pulses the unit start, holds the pipeline stalled until the ALU reports completion, and owns the architectural HI/LO registers.
- Handles pipeline flush and downstream hold without re-issuing or corrupting HI/LO.

Parameters:
TIMEOUT_CYC, 64, maximum cycles to wait for alu_opreat_over before abort and err pulse.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ex_valid  in  1  EX stage holds a valid instruction
ex_op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 treated as none
rs_val  in  32  rs operand (MTHI/MTLO source; muldiv A routed to ALU externally)
rt_val  in  32  rt operand (divisor check)
flush  in  1  exception/flush from older stage; cancels EX instruction
pipe_hold  in  1  downstream stall; EX instruction cannot advance
alu_mult_start  out  1  one-cycle start to multiplier
alu_mult_sign  out  1  1 = signed multiply
alu_diver_start  out  1  one-cycle start to divider
alu_div_sign  out  1  1 = signed divide
alu_opreat_over  in  1  1 = both units idle/finished
alu_mult_result  in  64  product {hi,lo}
alu_diver_result  in  64  {remainder,quotient}
ex_stall  out  1  hold EX stage
hi  out  32  architectural HI
lo  out  32  architectural LO
err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset values: state IDLE; hi=0, lo=0, pending regs=0, err=0, counter=0. All start outputs and ex_stall are 0 in reset.
- issue = ex_valid & !flush & op in {MULT, MULTU, DIV, DIVU} & !(op is DIV/DIVU & rt_val==0).
- pipe_hold does not block issue.
- Start outputs are combinational and asserted only in IDLE on issue, for exactly one cycle.
  - mult_sign = (op==MULT).
  - div_sign = (op==DIV).
  - Sign outputs are held stable from the issue cycle until completion.
- Divide by zero: no start, no stall, HI/LO unchanged, instruction retires normally.
- States: IDLE, WAIT0, WAIT, DONE, DRAIN.
  - IDLE: on issue go to WAIT0; ex_stall=1 that cycle.
  - WAIT0: alu_opreat_over is ignored (the ALU drops it one cycle after sampling start); go to WAIT.
  - WAIT: on alu_opreat_over=1, capture into pending {phi,plo} and go to DONE.
    - Mult capture: phi = result[63:32], plo = result[31:0].
    - Div capture: phi = remainder [63:32], plo = quotient [31:0].
  - DONE: ex_stall=0.
    - If flush: discard pending, go to IDLE.
    - Else if !pipe_hold: hi<=phi, lo<=plo, go to IDLE.
    - Else stay in DONE; no re-issue.
  - flush in WAIT0/WAIT: go to DRAIN, ex_stall drops next cycle, no HI/LO write.
  - DRAIN: wait for alu_opreat_over=1, then go to IDLE and discard the result. ex_stall=1 while a valid muldiv op is presented. MTHI/MTLO allowed.
- ex_stall = (IDLE & issue) | WAIT0 | WAIT | (DRAIN & ex_valid & muldiv op).
- MTHI/MTLO: in IDLE or DRAIN with ex_valid & !flush & !pipe_hold, write rs_val to hi/lo at the next edge; single cycle, no stall.
- Timeout: counter clears on entering WAIT0/DRAIN and increments each cycle in WAIT0/WAIT/DRAIN. On reaching TIMEOUT_CYC: err=1 for one cycle, go to IDLE, no HI/LO write.
- Reset mid-operation: all state to IDLE, hi/lo cleared; the ALU units are reset by the same rst.
- A new instruction sees updated hi/lo the cycle after DONE exits.

Test Plan:
- MULT rs=0xFFFFFFFD, rt=5, over returns 6 cycles after start:
  - start pulses 1 cycle, ex_stall high until completion.
  - After DONE: hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIVU 7/2 → lo=3, hi=1. DIV 0xFFFFFFF9/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - alu_div_sign=1 only for DIV.
- DIV rt=0 with hi=0x11, lo=0x22:
  - no start, ex_stall=0.
  - hi/lo stay 0x11/0x22.
- flush 2 cycles after MULT start:
  - DRAIN entered, hi/lo unchanged.
  - Next MULTU stalls until over=1, then issues; MTHI 0xABCD during DRAIN sets hi=0xABCD.
- pipe_hold=1 for 3 cycles at completion:
  - state holds in DONE, exactly one start pulse total.
  - hi/lo update on the cycle pipe_hold falls.
- alu_opreat_over tied 0 after start:
  - err pulses at TIMEOUT_CYC, returns to IDLE, hi/lo unchanged.
  - rst mid-WAIT clears hi/lo to 0.
